// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared data-bus slave port.
// One transaction in flight; slave read data lands SLAVE_LAT cycles after s_en.
module dbus_arbiter #(
  parameter int unsigned SLAVE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        s_en,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        s_en_q, s_en_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic        busy_q, busy_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        gnt;
  logic [31:0] rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= 3'd0;
      s_en_q     <= 1'b0;
      s_addr_q   <= 32'h0;
      s_wdata_q  <= 32'h0;
      s_wstrb_q  <= 4'h0;
      busy_q     <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      s_en_q     <= s_en_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      busy_q     <= busy_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Master 1 wins when alone, or when both ask and master 0 went last.
  assign gnt = m1_req & (~m0_req | ~last_q);
  assign rd  = (s_wstrb_q != 4'h0) ? 32'h0 : s_rdata;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    s_en_d     = 1'b0;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    busy_d     = busy_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          last_d    = gnt;
          s_addr_d  = gnt ? m1_addr : m0_addr;
          s_wdata_d = gnt ? m1_wdata : m0_wdata;
          s_wstrb_d = gnt ? m1_wstrb : m0_wstrb;
          s_en_d    = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(SLAVE_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (last_q) begin
            m1_rdata_d = rd;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = rd;
            m0_ack_d   = 1'b1;
          end
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign s_en     = s_en_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign busy     = busy_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC data bus.
- Shares the single data-memory/peripheral slave port between the CPU data port (master 0) and a second master (master 1, the program loader/debug port).
- Round-robin arbitration with a req/ack handshake; one transaction in flight at a time.
- Slave read data returns a fixed, parameterised number of cycles after the slave enable.

Parameters:
- SLAVE_LAT, 1, slave read latency in cycles from the s_en cycle to valid s_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock (BUFG output)
- rst  in  1  synchronous active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte write enables; 0 = read
- m0_rdata  out  32  master 0 read data; valid while m0_ack=1
- m0_ack  out  1  master 0 completion pulse, 1 cycle
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ack: same directions, widths and meanings as the m0_* ports, for master 1
- s_en  out  1  slave access strobe, 1 cycle per transaction
- s_addr  out  32  latched address
- s_wdata  out  32  latched write data
- s_wstrb  out  4  latched byte enables
- s_rdata  in  32  slave read data
- busy  out  1  high from grant until the ack cycle inclusive

Behaviour:
- All outputs are registered.
- Reset values: s_en=0, s_addr=0, s_wdata=0, s_wstrb=0, m0/m1_ack=0, m0/m1_rdata=0, busy=0, state=IDLE, last=1 (master 0 gets first priority).
- FSM:
  - IDLE: req sampled at the clock edge. Grant is chosen as follows:
    - only one req → that master;
    - both → the master != last.
  - On grant: latch the winner's addr/wdata/wstrb into s_*; set last=winner, busy=1; go to ISSUE.
  - No req → stay in IDLE.
  - ISSUE (1 cycle): s_en=1. Load counter=SLAVE_LAT; go to WAIT.
  - WAIT (SLAVE_LAT cycles): s_en=0; counter decrements.
    - In the final WAIT cycle, register s_rdata into the winner's rdata, or 32'h0 if s_wstrb!=0 (write).
    - Go to ACK.
  - ACK (1 cycle): winner's ack=1. Req inputs are ignored. Next state is IDLE; busy drops on the IDLE entry.
- Latency:
  - Req sampled in IDLE cycle T → s_en in T+1 → ack in T+2+SLAVE_LAT.
  - Back-to-back throughput is one transaction per SLAVE_LAT+3 cycles.
- Masters:
  - Must hold addr/wdata/wstrb/req stable until ack; values are latched at grant, so later changes have no effect.
  - Must drop req in the cycle after ack unless issuing a new transaction. A req high in IDLE is a new transaction.
- Non-granted master: its ack stays 0 and its rdata holds its previous value. Its pending req waits and wins the next IDLE arbitration (round-robin guarantees service within one transaction).
- s_addr/s_wdata/s_wstrb hold their last latched value outside ISSUE. Only s_en qualifies them.
- Writes: s_wstrb passed through unmodified (any nonzero pattern). The slave performs the byte write in the s_en cycle.
- Reset mid-transaction (any state): next cycle all outputs at reset values; the in-flight transaction is abandoned with no ack. Masters re-arbitrate after rst deasserts, with master 0 first.
- rst has priority over all other inputs in the same cycle.

Test Plan:
- Reset: assert rst 2 cycles with random inputs → all outputs 0 and busy=0. After release with no req, s_en stays 0 for 10 cycles.
- Single read, SLAVE_LAT=1: m0_req at T with addr 0x100, wstrb 0; slave returns 0xDEADBEEF in cycle T+2. Required response:
  - s_en=1 and s_addr=0x100 at T+1;
  - m0_ack=1 with m0_rdata=0xDEADBEEF at T+3;
  - m1_ack=0 throughout.
- Write by master 1: addr 0x2000000, wdata 0x5, wstrb 0xF at T → s_en at T+1 with s_wdata=0x5, s_wstrb=0xF; m1_ack at T+3 with m1_rdata=0.
- Simultaneous reqs after reset, both held until their acks, SLAVE_LAT=1:
  - m0 served first, with m0_ack at T+3;
  - m1 then gets s_en at T+5 and m1_ack at T+7.
- Fairness, SLAVE_LAT=4: both masters re-request immediately after every ack for 6 transactions → grant order 0,1,0,1,0,1. Each ack is exactly SLAVE_LAT+3=7 cycles after the previous one.
- Reset in WAIT: m0 read granted, rst high in first WAIT cycle → next cycle s_en=0, busy=0, and no m0_ack ever. After release with m0_req still high → new s_en one cycle after the first IDLE cycle, with ack SLAVE_LAT+2 cycles after that IDLE cycle.
